// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes 11-bit frames,
// strips E0/F0 prefixes and strobes out make codes.
module ps2_key_receiver #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyCode,
    output logic       dataReady,
    output logic       extended,
    output logic       frameErr
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [3:0]  F_MAX  = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYC - 1);

    state_t      state, state_n;
    logic [1:0]  clk_sync, dat_sync;
    logic        filt, filt_d;
    logic [3:0]  fcnt;
    logic        strobe, bit_in;
    logic [7:0]  shreg;
    logic [2:0]  bitcnt;
    logic        par;
    logic [15:0] tcnt;
    logic        timeout, byte_valid, frame_bad;
    logic        ext_pend, brk_pend;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            fcnt     <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            filt_d   <= filt;
            // Level flips only after FILTER_LEN samples disagreeing in a row
            if (clk_sync[1] == filt) begin
                fcnt <= '0;
            end else if (fcnt == F_MAX) begin
                filt <= clk_sync[1];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 4'd1;
            end
        end
    end

    assign strobe  = filt_d & ~filt;
    assign bit_in  = dat_sync[1];
    assign timeout = (state != IDLE) && !strobe && (tcnt == TO_MAX);

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        byte_valid = 1'b0;
        frame_bad  = 1'b0;
        if (timeout) begin
            state_n   = IDLE;
            frame_bad = 1'b1;
        end else if (strobe) begin
            case (state)
                IDLE:   if (!bit_in) state_n = DATA;
                DATA:   if (bitcnt == 3'd7) state_n = PARITY;
                PARITY: state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if (bit_in && (^{shreg, par})) byte_valid = 1'b1;
                    else                           frame_bad  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            tcnt   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
        end else begin
            if (state == IDLE || strobe) tcnt <= '0;
            else                         tcnt <= tcnt + 16'd1;
            if (strobe) begin
                case (state)
                    IDLE:   bitcnt <= '0;
                    DATA: begin
                        shreg  <= {bit_in, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY: par <= bit_in;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            keyCode   <= '0;
            dataReady <= 1'b0;
            extended  <= 1'b0;
            frameErr  <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            dataReady <= 1'b0;
            if (frame_bad) begin
                frameErr <= 1'b1;
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_valid) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (brk_pend) begin
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end else begin
                    keyCode   <= shreg;
                    extended  <= ext_pend;
                    dataReady <= 1'b1;
                    ext_pend  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Upstream keyboard front end for the typewriter/calculator top level.
- Deserialises PS/2 keyboard frames and checks start, parity and stop bits.
- Strips break (F0) and extended (E0) prefixes.
- Presents each key-press make code on keyCode with a one-cycle dataReady strobe. These outputs feed the keyCode-to-ASCII translator and the VGA typewriter's dataReady input.

Parameters:
- FILTER_LEN, 4: consecutive equal synchronised samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYC, 50000: idle clk_50m cycles allowed between bit strobes inside a frame (1 ms at 50 MHz). The counter is 16 bits.

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock from the keyboard (asynchronous, idles high)
- ps2_data  in  1  raw PS/2 data from the keyboard (asynchronous, idles high)
- keyCode  out  8  last accepted make code; held until the next accepted code
- dataReady  out  1  one-cycle strobe, high when keyCode has just been updated
- extended  out  1  high when the current keyCode was preceded by E0
- frameErr  out  1  sticky error flag: parity, start/stop or timeout failure

Behaviour:
- Reset (async, rst=1): keyCode=0, dataReady=0, extended=0, frameErr=0. FSM goes to IDLE. Bit counter, timeout counter and prefix flags clear. Synchroniser and filter state preset to 1 (line idle).
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered clock level changes only after FILTER_LEN consecutive equal synchronised ps2_clk samples.
  - strobe = filtered clock 1→0 transition. It lasts one cycle.
  - The synchronised ps2_data value is sampled on the strobe cycle.
- Frame FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: strobe with data=0 → DATA, bitcnt=0. Strobe with data=1 is ignored and the FSM stays in IDLE.
  - DATA: each strobe shifts data in LSB first. After the 8th bit → PARITY.
  - PARITY: strobe captures the parity bit → STOP. Parity is odd: the eight data bits plus the parity bit must contain an odd number of ones.
  - STOP: strobe → IDLE. If stop=1 and parity is good, the byte is valid for one cycle (byteValid). Otherwise frameErr←1 and the byte is discarded.
- Timeout:
  - The counter clears on every strobe and while in IDLE.
  - In any other state, reaching TIMEOUT_CYC-1 forces the FSM to IDLE and sets frameErr←1.
- Prefix decoder, acting on byteValid:
  - byte=E0: extPend←1.
  - byte=F0: brkPend←1.
  - Other byte with brkPend=1: key release; no output. Clear brkPend and extPend.
  - Other byte with brkPend=0: keyCode←byte, extended←extPend, dataReady←1. Clear extPend.
  - Any frame error or timeout clears extPend and brkPend.
- Latency: dataReady rises on the clock edge after the stop-bit strobe cycle (1 cycle). It is high for exactly 1 cycle, then drops.
- frameErr is cleared only by rst. A frame error does not block reception of later frames.
- keyCode and extended change only on a dataReady cycle.
- Reset mid-frame aborts immediately: the partial frame is lost and no dataReady is produced. The next complete frame after rst is received normally.
- Boundary cases:
  - Back-to-back frames with no idle gap are accepted: the start-bit strobe is taken in IDLE.
  - A glitch shorter than FILTER_LEN cycles produces no strobe.
  - Consecutive E0 bytes keep extPend=1.
  - F0 E0 is treated as release-pending, with extPend set by the E0.

Test Plan:
- Valid frame 0x1C (parity 0), bit period 40 µs → exactly one dataReady pulse of 1 cycle, keyCode=0x1C, extended=0, frameErr=0.
- Sequence F0, 1C → no dataReady; keyCode stays 0x1C from the prior test; brkPend cleared. A following 1C → dataReady with keyCode=0x1C.
- Sequence E0, 75 → dataReady, keyCode=0x75, extended=1. Then 1C → keyCode=0x1C, extended=0.
- Frame 0x5A with parity bit inverted → no dataReady, frameErr=1. Next valid 0x5A → dataReady, keyCode=0x5A; frameErr stays 1.
- Frame stopped after 5 data bits, lines held high for 1.1 ms → frameErr=1, FSM back to IDLE. Next valid 0x29 → keyCode=0x29, dataReady pulse.
- 2-cycle low glitch on ps2_clk → no bit consumed; a following valid 0x16 decodes correctly.
- rst asserted during bit 4 of a frame → all outputs 0 immediately, no dataReady; a fresh 0x16 afterwards → keyCode=0x16.
